// File: rtl/pixel_frame_loader_if.sv
`default_nettype none
// ============================================================================
// pixel_frame_loader_if : pixel stream, core launch/result and status bundle
// Rev 1.0
// ============================================================================
interface pixel_frame_loader_if #(
    parameter int NPIX = 784
);
    logic            pix_valid;
    logic            pix_sof;
    logic            pix_value;
    logic            pix_ready;
    logic [NPIX-1:0] pixel_data;
    logic            nn_start;
    logic            nn_done;
    logic [3:0]      nn_argmax;
    logic [3:0]      result_digit;
    logic            result_valid;
    logic            busy;
    logic            timeout_err;
    logic            sync_err;

    // master: pixel source plus inference core; slave: the loader
    modport master (
        output pix_valid, pix_sof, pix_value, nn_done, nn_argmax,
        input  pix_ready, pixel_data, nn_start, result_digit, result_valid,
               busy, timeout_err, sync_err
    );

    modport slave (
        input  pix_valid, pix_sof, pix_value, nn_done, nn_argmax,
        output pix_ready, pixel_data, nn_start, result_digit, result_valid,
               busy, timeout_err, sync_err
    );
endinterface
`default_nettype wire

// File: rtl/pixel_frame_loader.sv
`default_nettype none
// ============================================================================
// pixel_frame_loader : packs a raster 1-bit pixel stream into an image,
// launches the inference core and holds its argmax result.   Rev 1.0
// ============================================================================
module pixel_frame_loader #(
    parameter int NPIX    = 784,
    parameter int TIMEOUT = 200000
) (
    input  wire logic            clk,
    input  wire logic            reset,
    pixel_frame_loader_if.slave  bus
);
    localparam int             WDW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [9:0]     LAST    = 10'(NPIX - 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_LAUNCH  = 2'd2,
        S_WAIT_NN = 2'd3
    } state_t;

    state_t          state_q;
    logic [9:0]      cnt_q;
    logic [WDW-1:0]  wd_q;
    logic [NPIX-1:0] pixel_data_q;
    logic            pix_ready_q;
    logic            nn_start_q;
    logic [3:0]      result_digit_q;
    logic            result_valid_q;
    logic            busy_q;
    logic            timeout_err_q;
    logic            sync_err_q;

    logic            xfer;
    assign xfer = bus.pix_valid & pix_ready_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            wd_q           <= '0;
            pixel_data_q   <= '0;
            pix_ready_q    <= 1'b0;
            nn_start_q     <= 1'b0;
            result_digit_q <= 4'hF;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            timeout_err_q  <= 1'b0;
            sync_err_q     <= 1'b0;
        end else begin
            nn_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    pix_ready_q <= 1'b1;
                    if (xfer && bus.pix_sof) begin
                        pixel_data_q[0] <= bus.pix_value;
                        cnt_q           <= 10'd1;
                        state_q         <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (xfer) begin
                        if (bus.pix_sof) begin
                            pixel_data_q[0] <= bus.pix_value;
                            cnt_q           <= 10'd1;
                            sync_err_q      <= 1'b1;
                        end else begin
                            pixel_data_q[cnt_q] <= bus.pix_value;
                            if (cnt_q == LAST) begin
                                // outputs registered here so they are valid during LAUNCH itself
                                cnt_q          <= '0;
                                state_q        <= S_LAUNCH;
                                nn_start_q     <= 1'b1;
                                busy_q         <= 1'b1;
                                result_valid_q <= 1'b0;
                                pix_ready_q    <= 1'b0;
                            end else begin
                                cnt_q <= cnt_q + 10'd1;
                            end
                        end
                    end
                end
                S_LAUNCH: begin
                    wd_q    <= '0;
                    state_q <= S_WAIT_NN;
                end
                S_WAIT_NN: begin
                    // a done on the timeout cycle still counts as success
                    if (bus.nn_done) begin
                        result_digit_q <= bus.nn_argmax;
                        result_valid_q <= 1'b1;
                        wd_q           <= '0;
                        busy_q         <= 1'b0;
                        pix_ready_q    <= 1'b1;
                        state_q        <= S_IDLE;
                    end else if (wd_q == WD_LAST) begin
                        timeout_err_q <= 1'b1;
                        wd_q          <= '0;
                        busy_q        <= 1'b0;
                        pix_ready_q   <= 1'b1;
                        state_q       <= S_IDLE;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.pix_ready    = pix_ready_q;
    assign bus.pixel_data   = pixel_data_q;
    assign bus.nn_start     = nn_start_q;
    assign bus.result_digit = result_digit_q;
    assign bus.result_valid = result_valid_q;
    assign bus.busy         = busy_q;
    assign bus.timeout_err  = timeout_err_q;
    assign bus.sync_err     = sync_err_q;
endmodule
`default_nettype wire

// File: tb/tb_pixel_frame_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_pixel_frame_loader : directed scoreboard bench for pixel_frame_loader
// Rev 1.0
// ============================================================================
module tb_pixel_frame_loader;
    localparam int NPIX = 784;
    localparam int TMO  = 64;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pixel_frame_loader_if #(.NPIX(NPIX)) bus ();

    pixel_frame_loader #(.NPIX(NPIX), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int tests   = 0;
    int fails   = 0;
    int n_start = 0;
    logic [NPIX-1:0] q_img[$];
    logic [3:0]      q_dig[$];

    always @(posedge clk) if (bus.nn_start === 1'b1) n_start <= n_start + 1;

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global time limit");
    end

    function automatic logic pix_fn(input int pat, input int i);
        case (pat)
            0:       return (i % 3) == 0;
            1:       return 1'b1;
            2:       return (i % 2) == 0;
            default: return ((i * 7) % 5) == 1;
        endcase
    endfunction

    function automatic logic [NPIX-1:0] img_of(input int pat);
        logic [NPIX-1:0] m;
        for (int i = 0; i < NPIX; i++) m[i] = pix_fn(pat, i);
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_img(input string tag, input logic [NPIX-1:0] exp);
        logic [NPIX-1:0] diff;
        int first;
        diff  = bus.pixel_data ^ exp;
        first = -1;
        for (int i = NPIX - 1; i >= 0; i--) if (diff[i] !== 1'b0) first = i;
        tests++;
        assert (bus.pixel_data === exp) else begin
            fails++;
            $error("FAIL %s: observed image differs from expected, first differing bit %0d", tag, first);
        end
    endtask

    task automatic chk_reset(input string t);
        chk({t, "_ready"},  bus.pix_ready,    0);
        chk({t, "_start"},  bus.nn_start,     0);
        chk({t, "_digit"},  bus.result_digit, 4'hF);
        chk({t, "_rvalid"}, bus.result_valid, 0);
        chk({t, "_busy"},   bus.busy,         0);
        chk({t, "_tmo"},    bus.timeout_err,  0);
        chk({t, "_sync"},   bus.sync_err,     0);
        chk_img({t, "_img"}, '0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.pix_valid = 1'b0;
        bus.nn_done   = 1'b0;
        tick();
        chk_reset("reset");
        reset = 1'b0;
        tick();
    endtask

    task automatic send_pixel(input bit sof, input logic v, input bit gaps);
        bit acc;
        acc = 1'b0;
        if (gaps) begin
            int g;
            g = $urandom_range(0, 2);
            repeat (g) begin
                bus.pix_valid = 1'b0;
                bus.pix_sof   = 1'b1;
                bus.pix_value = ~v;
                tick();
            end
        end
        bus.pix_valid = 1'b1;
        bus.pix_sof   = sof;
        bus.pix_value = v;
        for (int k = 0; k < 20 && !acc; k++) begin
            acc = (bus.pix_ready === 1'b1);
            tick();
        end
        if (!acc) chk("pix_accept_timeout", 0, 1);
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
    endtask

    task automatic send_pixels(input int pat, input int n, input bit first_sof, input bit gaps);
        for (int i = 0; i < n; i++) send_pixel(first_sof && (i == 0), pix_fn(pat, i), gaps);
    endtask

    // Called right after the final pixel's accepting edge.
    task automatic expect_launch(input string t, input int s0);
        logic [NPIX-1:0] e;
        chk({t, "_start"},   bus.nn_start,     1);
        chk({t, "_busy"},    bus.busy,         1);
        chk({t, "_rvclr"},   bus.result_valid, 0);
        chk({t, "_ready0"},  bus.pix_ready,    0);
        chk({t, "_noearly"}, n_start - s0,     0);
        e = q_img.pop_front();
        chk_img({t, "_img"}, e);
        tick();
        chk({t, "_pulse1"},  bus.nn_start,     0);
        chk({t, "_nstart"},  n_start - s0,     1);
    endtask

    task automatic core_done(input int n, input logic [3:0] d);
        logic [3:0] e;
        repeat (n - 1) tick();
        bus.nn_done   = 1'b1;
        bus.nn_argmax = d;
        q_dig.push_back(d);
        tick();
        bus.nn_done   = 1'b0;
        bus.nn_argmax = 4'h0;
        e = q_dig.pop_front();
        chk("done_digit",  bus.result_digit, e);
        chk("done_rvalid", bus.result_valid, 1);
        chk("done_busy",   bus.busy,         0);
        chk("done_ready",  bus.pix_ready,    1);
    endtask

    initial begin
        int s0;
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
        bus.pix_value = 1'b0;
        bus.nn_done   = 1'b0;
        bus.nn_argmax = 4'h0;

        // reset state, then ready comes up in IDLE
        tick();
        chk_reset("por");
        reset = 1'b0;
        tick();
        chk("idle_ready", bus.pix_ready, 1);

        // frame of (i%3==0), core answers 7 after 50 cycles
        s0 = n_start;
        q_img.push_back(img_of(0));
        send_pixels(0, NPIX, 1, 0);
        expect_launch("f1", s0);
        core_done(49, 4'd7);

        // second frame: result_valid drops at launch, digit held while busy
        s0 = n_start;
        q_img.push_back(img_of(2));
        send_pixels(2, NPIX, 1, 0);
        chk("f2_digit_held", bus.result_digit, 4'd7);
        expect_launch("f2", s0);
        core_done(30, 4'd3);
        chk("f2_nosync", bus.sync_err, 0);

        // 100 pixels, then resync into an all-ones frame
        s0 = n_start;
        send_pixels(0, 100, 1, 0);
        q_img.push_back(img_of(1));
        send_pixels(1, NPIX, 1, 0);
        chk("rs_sync", bus.sync_err, 1);
        expect_launch("rs", s0);
        core_done(5, 4'd5);

        // pixels without sof in IDLE are dropped
        s0 = n_start;
        send_pixels(2, 300, 0, 0);
        chk_img("drop_img", img_of(1));
        chk("drop_nstart", n_start - s0, 0);
        chk("drop_busy", bus.busy, 0);

        // gapped valid: only handshaked pixels count
        q_img.push_back(img_of(3));
        send_pixels(3, NPIX, 1, 1);
        expect_launch("gap", s0);
        core_done(12, 4'd9);

        // done on the very timeout cycle wins
        do_reset();
        s0 = n_start;
        q_img.push_back(img_of(0));
        send_pixels(0, NPIX, 1, 0);
        expect_launch("edge", s0);
        core_done(TMO, 4'd8);
        chk("edge_notmo", bus.timeout_err, 0);

        // core never answers
        do_reset();
        s0 = n_start;
        q_img.push_back(img_of(0));
        send_pixels(0, NPIX, 1, 0);
        expect_launch("tmo", s0);
        repeat (TMO - 1) tick();
        chk("tmo_pre_err",  bus.timeout_err, 0);
        chk("tmo_pre_busy", bus.busy,        1);
        tick();
        chk("tmo_err",    bus.timeout_err,  1);
        chk("tmo_busy",   bus.busy,         0);
        chk("tmo_rvalid", bus.result_valid, 0);
        chk("tmo_digit",  bus.result_digit, 4'hF);
        chk("tmo_ready",  bus.pix_ready,    1);
        bus.nn_done   = 1'b1;
        bus.nn_argmax = 4'd2;
        tick();
        bus.nn_done   = 1'b0;
        chk("late_rvalid", bus.result_valid, 0);
        chk("late_digit",  bus.result_digit, 4'hF);
        chk("late_busy",   bus.busy,         0);
        s0 = n_start;
        q_img.push_back(img_of(2));
        send_pixels(2, NPIX, 1, 0);
        expect_launch("post_tmo", s0);
        core_done(10, 4'd4);
        chk("post_tmo_sticky", bus.timeout_err, 1);

        // reset at pixel 400
        s0 = n_start;
        send_pixels(0, 400, 1, 0);
        reset = 1'b1;
        tick();
        chk_reset("rst_mid");
        reset = 1'b0;
        tick();
        chk("rst_mid_ready", bus.pix_ready, 1);
        chk("rst_mid_nstart", n_start - s0, 0);

        // reset during WAIT_NN
        q_img.push_back(img_of(3));
        send_pixels(3, NPIX, 1, 0);
        expect_launch("rst_wait", s0);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        chk_reset("rst_wait");
        reset = 1'b0;
        repeat (3) tick();
        chk("rst_wait_nstart", n_start - s0, 1);

        // recovery frame classifies normally
        s0 = n_start;
        q_img.push_back(img_of(1));
        send_pixels(1, NPIX, 1, 1);
        expect_launch("recover", s0);
        core_done(20, 4'd6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/pixel_frame_loader.md
Name: pixel_frame_loader

Overview:
- Upstream feeder for the neural_network inference core.
- Accepts a raster-order stream of 1-bit pixels over a valid/ready handshake and packs them into the 784-bit pixel_data image.
- Issues a one-cycle start pulse to the core, waits for its done, then latches and holds the argmax digit for display logic.
- Also handles frame resync and a watchdog timeout on the core.

Parameters:
- NPIX, 784, pixels per frame (28x28).
- TIMEOUT, 200000, max cycles to wait for nn_done before abort.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- pix_valid  input  1  source has a pixel on pix_value.
- pix_sof  input  1  qualifies the current pixel as pixel 0 of a frame; meaningful only with pix_valid.
- pix_value  input  1  pixel bit (1 = ink).
- pix_ready  output  1  loader accepts a pixel this cycle.
- pixel_data  output  784  packed image to the core; pixel index i = row*28+col is bit i.
- nn_start  output  1  one-cycle start pulse to the core.
- nn_done  input  1  core completion (one-cycle pulse).
- nn_argmax  input  4  core result, valid when nn_done=1.
- result_digit  output  4  last classified digit.
- result_valid  output  1  result_digit holds a completed classification.
- busy  output  1  a frame is with the core (LAUNCH or WAIT_NN).
- timeout_err  output  1  sticky: the core failed to finish within TIMEOUT.
- sync_err  output  1  sticky: frame resync occurred.

Behaviour:
- Reset values:
  - pix_ready=0, nn_start=0, pixel_data=0, result_digit=4'hF, result_valid=0, busy=0, timeout_err=0, sync_err=0.
  - State=IDLE; pixel counter=0; watchdog=0.
- Handshake:
  - A pixel transfers on a clk edge with pix_valid & pix_ready.
  - pix_ready=1 only in IDLE and COLLECT.
- IDLE (pix_ready=1):
  - A transfer without pix_sof is dropped.
  - A transfer with pix_sof writes pixel_data[0], sets counter=1 and goes to COLLECT.
  - pixel_data is not cleared at frame start; every bit is overwritten during the frame.
- COLLECT (pix_ready=1):
  - Each transfer writes pixel_data[counter] and increments counter.
  - A transfer with pix_sof mid-frame writes bit 0, sets counter=1, sets sync_err and stays in COLLECT (resync).
  - On the transfer with counter=NPIX-1, write the final bit and go to LAUNCH. The counter never reaches NPIX.
- LAUNCH:
  - nn_start=1 for exactly this one cycle.
  - busy=1; result_valid cleared to 0.
  - Go to WAIT_NN.
- WAIT_NN:
  - busy=1; watchdog increments each cycle.
  - On nn_done: result_digit<=nn_argmax, result_valid<=1, watchdog<=0, go to IDLE.
  - If the watchdog reaches TIMEOUT-1 without nn_done: timeout_err<=1, result_valid stays 0, result_digit unchanged, go to IDLE.
  - If nn_done arrives on the same cycle as the timeout, nn_done wins and no error is raised.
- Latency and data stability:
  - Last pixel accepted at edge N gives nn_start high in cycle N+1.
  - pixel_data is stable from LAUNCH until return to IDLE, because no pixels are accepted while busy.
- nn_done outside WAIT_NN is ignored.
- Sticky flags clear only on reset.
- Reset asserted mid-frame or mid-inference:
  - Returns to IDLE next edge with all reset values.
  - nn_start is never asserted during or after a reset cycle.
- Counter width: 10 bits. Watchdog width: ceil(log2(TIMEOUT)) bits.

Test Plan:
- Reset, then stream 784 pixels with pix_sof on the first, value = (i%3==0), pix_valid continuously high -> pixel_data[i]=(i%3==0) for all i; one nn_start pulse exactly 1 cycle after the 784th transfer; busy=1.
- Model the core returning nn_done with nn_argmax=7 after 50 cycles -> result_digit=7, result_valid=1, state IDLE, pix_ready=1; a second frame clears result_valid at its LAUNCH and latches the new digit.
- Send 100 pixels, then pix_sof plus 784 pixels of all-ones -> sync_err=1; pixel_data all ones; exactly one nn_start, issued after the 784th post-resync pixel.
- Drive 300 pixels without pix_sof in IDLE -> no counter change, pixel_data unchanged, no nn_start; with pix_valid toggling randomly mid-frame -> only handshaked pixels counted.
- TIMEOUT=64 and the core never responds -> timeout_err=1 after 64 WAIT_NN cycles; result_valid=0; result_digit=4'hF; loader accepts a new frame; a late nn_done pulse is ignored.
- Assert reset for 1 cycle at pixel 400 and again during WAIT_NN -> all outputs at reset values next cycle, no nn_start, and the following full frame classifies normally.
